// File: rtl/vecmac_requant_packer_pkg.sv
// Shared widths, saturation limits and structs for the VECMAC requantizer/packer.
// Imported by the output interface, the result FIFO and the top module.
package vecmac_pkg;

    localparam int ACCUM_WIDTH = 32;
    localparam int OUT_WIDTH   = 8;
    localparam int PACK        = 4;
    localparam int MULT_WIDTH  = 16;
    localparam int SHIFT_WIDTH = 6;
    localparam int WORD_WIDTH  = PACK * OUT_WIDTH;
    localparam int COUNT_WIDTH = 3;
    localparam int PROD_WIDTH  = ACCUM_WIDTH + MULT_WIDTH;

    localparam logic signed [OUT_WIDTH-1:0] SAT_MAX = 8'sh7f;
    localparam logic signed [OUT_WIDTH-1:0] SAT_MIN = 8'sh80;

    typedef struct packed {
        logic signed [MULT_WIDTH-1:0] scale_mult;
        logic [SHIFT_WIDTH-1:0]       scale_shift;
        logic signed [OUT_WIDTH-1:0]  zero_point;
        logic                         relu_en;
    } requant_cfg_t;

    typedef struct packed {
        logic [WORD_WIDTH-1:0]  data;
        logic [COUNT_WIDTH-1:0] count;
    } out_word_t;

endpackage

// File: rtl/vecmac_requant_packer_if.sv
// Ready/valid stream of packed int8 words leaving the requantizer.
// master = producer (the packer), slave = consumer (TTA bus or activation store).
interface vecmac_requant_packer_if;
    import vecmac_pkg::*;

    logic [WORD_WIDTH-1:0]  out_data;
    logic [COUNT_WIDTH-1:0] out_count;
    logic                   out_valid;
    logic                   out_ready;

    modport master (output out_data, output out_count, output out_valid, input out_ready);
    modport slave  (input out_data, input out_count, input out_valid, output out_ready);
endinterface

// File: rtl/vecmac_result_fifo.sv
// First-word-fall-through FIFO with occupancy level; a push into a full FIFO
// that is not popped in the same cycle is dropped and reported on drop.
module vecmac_result_fifo #(
    parameter int  WIDTH = 35,
    parameter int  DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             ready,
    output logic [WIDTH-1:0] rd_data,
    output logic             valid,
    output logic             full,
    output logic [AW:0]      level,
    output logic             drop
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign valid   = (level != '0);
    assign full    = (level == (AW+1)'(DEPTH));
    assign do_pop  = valid && ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;
    assign rd_data = valid ? mem[rd_ptr] : '0;

    // NOTE: storage has no reset; occupancy is tracked by pointers and level,
    // and the read port is gated to zero while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end
endmodule

// File: rtl/vecmac_requant_packer.sv
// Requantizes VECMAC accumulator results to int8 (scale, round, shift, ReLU,
// zero point, saturate), packs lanes into 32-bit words and buffers them.
module vecmac_requant_packer
    import vecmac_pkg::*;
#(
    parameter int  FIFO_DEPTH = 8,
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [ACCUM_WIDTH-1:0]        in_result,
    input  logic                          in_valid,
    input  logic [MULT_WIDTH-1:0]         scale_mult,
    input  logic [SHIFT_WIDTH-1:0]        scale_shift,
    input  logic [OUT_WIDTH-1:0]          zero_point,
    input  logic                          relu_en,
    input  logic                          flush,
    input  logic                          clear_status,
    vecmac_requant_packer_if.master       out_bus,
    output logic [LVL_W-1:0]              fifo_level,
    output logic                          overflow_sticky,
    output logic [15:0]                   sat_count
);
    localparam int RND_W = PROD_WIDTH + 1;  // room for the rounding bias
    localparam int VAL_W = RND_W + 1;       // room for the zero-point add
    localparam int IDX_W = $clog2(PACK);

    // R1: product and the config that belongs to it
    logic                          v1;
    logic signed [PROD_WIDTH-1:0]  prod1;
    requant_cfg_t                  cfg1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            prod1 <= '0;
            cfg1  <= '0;
        end else begin
            v1 <= in_valid;
            if (in_valid) begin
                prod1 <= PROD_WIDTH'($signed(in_result)) * PROD_WIDTH'($signed(scale_mult));
                cfg1  <= '{scale_mult, scale_shift, zero_point, relu_en};
            end
        end
    end

    // R2: round-half-up shift, ReLU, zero point, clamp
    logic signed [RND_W-1:0]     bias, rounded;
    logic signed [VAL_W-1:0]     shifted_zp;
    logic signed [OUT_WIDTH-1:0] lane_d;
    logic                        clamp_d;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and a latch cannot be inferred.
        bias    = '0;
        clamp_d = 1'b0;
        if (cfg1.scale_shift != '0) bias = RND_W'(1) << (cfg1.scale_shift - 6'd1);
        rounded = (RND_W'(prod1) + bias) >>> cfg1.scale_shift;
        if (cfg1.relu_en && rounded < 0) rounded = '0;
        shifted_zp = VAL_W'(rounded) + VAL_W'(cfg1.zero_point);
        lane_d     = shifted_zp[OUT_WIDTH-1:0];
        if (shifted_zp > VAL_W'(SAT_MAX)) begin
            lane_d  = SAT_MAX;
            clamp_d = 1'b1;
        end else if (shifted_zp < VAL_W'(SAT_MIN)) begin
            lane_d  = SAT_MIN;
            clamp_d = 1'b1;
        end
    end

    logic                  v2;
    logic [OUT_WIDTH-1:0]  lane2;
    logic                  sat_evt;

    assign sat_evt = v1 && clamp_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2        <= 1'b0;
            lane2     <= '0;
            sat_count <= '0;
        end else begin
            v2    <= v1;
            lane2 <= lane_d;
            // A saturation in the same cycle as clear_status restarts at 1.
            if (sat_evt)           sat_count <= clear_status ? 16'd1
                                              : (sat_count == 16'hffff) ? sat_count : sat_count + 16'd1;
            else if (clear_status) sat_count <= '0;
        end
    end

    // R3: packer; a lane arriving with flush is included before the flush push
    logic [WORD_WIDTH-1:0]  pack_word, lane_word;
    logic [IDX_W-1:0]       lane_idx;
    logic [COUNT_WIDTH-1:0] fill;
    logic                   push_now, push_q;
    out_word_t              push_word_q;

    always_comb begin
        lane_word = pack_word;
        if (v2) lane_word[lane_idx*OUT_WIDTH +: OUT_WIDTH] = lane2;
        fill     = COUNT_WIDTH'(lane_idx) + COUNT_WIDTH'(v2);
        push_now = (fill == COUNT_WIDTH'(PACK)) || (flush && fill != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pack_word   <= '0;
            lane_idx    <= '0;
            push_q      <= 1'b0;
            push_word_q <= '0;
        end else begin
            push_q      <= push_now;
            push_word_q <= '{lane_word, fill};
            if (push_now) begin
                pack_word <= '0;
                lane_idx  <= '0;
            end else begin
                pack_word <= lane_word;
                lane_idx  <= fill[IDX_W-1:0];
            end
        end
    end

    out_word_t fifo_rd;
    logic      fifo_full, fifo_drop;

    vecmac_result_fifo #(
        .WIDTH ($bits(out_word_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_q),
        .push_data (push_word_q),
        .ready     (out_bus.out_ready),
        .rd_data   (fifo_rd),
        .valid     (out_bus.out_valid),
        .full      (fifo_full),
        .level     (fifo_level),
        .drop      (fifo_drop)
    );

    assign out_bus.out_data  = fifo_rd.data;
    assign out_bus.out_count = fifo_rd.count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            overflow_sticky <= 1'b0;
        else if (fifo_drop)    overflow_sticky <= 1'b1;
        else if (clear_status) overflow_sticky <= 1'b0;
    end
endmodule

// File: tb/tb_vecmac_requant_packer.sv
// Directed-vector bench for vecmac_requant_packer: arithmetic, packing,
// flush, overflow/drop, status clear and mid-stream reset.
module tb_vecmac_requant_packer;
    import vecmac_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_result;
    logic        in_valid;
    logic [15:0] scale_mult;
    logic [5:0]  scale_shift;
    logic [7:0]  zero_point;
    logic        relu_en;
    logic        flush;
    logic        clear_status;
    logic [3:0]  fifo_level;
    logic        overflow_sticky;
    logic [15:0] sat_count;

    int n_checks = 0;
    int n_fail   = 0;

    vecmac_requant_packer_if bus ();

    vecmac_requant_packer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_result       (in_result),
        .in_valid        (in_valid),
        .scale_mult      (scale_mult),
        .scale_shift     (scale_shift),
        .zero_point      (zero_point),
        .relu_en         (relu_en),
        .flush           (flush),
        .clear_status    (clear_status),
        .out_bus         (bus),
        .fifo_level      (fifo_level),
        .overflow_sticky (overflow_sticky),
        .sat_count       (sat_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_cfg(input logic [15:0] m, input logic [5:0] s, input logic [7:0] zp, input logic relu);
        scale_mult  = m;
        scale_shift = s;
        zero_point  = zp;
        relu_en     = relu;
    endtask

    // Called at a negedge; the value is sampled on the following posedge.
    task automatic drive(input logic [31:0] v);
        in_result = v;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_word(input string tag);
        int n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    endtask

    task automatic expect_pop(input string tag, input logic [31:0] data, input logic [2:0] cnt);
        wait_word(tag);
        check({tag, "_data"}, 64'(bus.out_data), 64'(data));
        check({tag, "_count"}, 64'(bus.out_count), 64'(cnt));
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_data"}, 64'(bus.out_data), 64'd0);
        check({tag, "_count"}, 64'(bus.out_count), 64'd0);
        check({tag, "_level"}, 64'(fifo_level), 64'd0);
        check({tag, "_sticky"}, 64'(overflow_sticky), 64'd0);
        check({tag, "_sat"}, 64'(sat_count), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        in_result = '0;
        in_valid = 1'b0;
        flush = 1'b0;
        clear_status = 1'b0;
        bus.out_ready = 1'b0;
        set_cfg(16'd16384, 6'd14, 8'd0, 1'b0);
        idle(3);
        check_reset_state("reset");
        rst_n = 1'b1;
        idle(2);

        // Identity scale with latency: 4th lane sampled at t, visible after t+3
        for (int i = 1; i <= 4; i++) drive(32'(i));
        idle(2);
        check("lat_not_yet", 64'(bus.out_valid), 64'd0);
        idle(1);
        check("lat_t3", 64'(bus.out_valid), 64'd1);
        expect_pop("ident", 32'h04030201, 3'd4);
        check("ident_empty", 64'(bus.out_valid), 64'd0);

        // Round-half-up with shift 1
        set_cfg(16'd1, 6'd1, 8'd0, 1'b0);
        drive(32'd3);
        drive(-32'sd3);
        drive(32'd5);
        drive(-32'sd5);
        expect_pop("round", 32'hFE03FF02, 3'd4);

        // Saturation both ways, ReLU with zero point, then a plain lane
        set_cfg(16'd16384, 6'd14, 8'd0, 1'b0);
        drive(32'd1000);
        drive(-32'sd1000);
        set_cfg(16'd16384, 6'd14, 8'd10, 1'b1);
        drive(-32'sd5);
        set_cfg(16'd16384, 6'd14, 8'd0, 1'b0);
        drive(32'd7);
        expect_pop("sat_relu", 32'h070A807F, 3'd4);
        check("sat_count2", 64'(sat_count), 64'd2);

        // Partial word via flush, then an empty flush
        drive(32'd5);
        drive(32'd6);
        idle(3);
        flush = 1'b1;
        idle(1);
        flush = 1'b0;
        expect_pop("flush", 32'h00000605, 3'd2);
        flush = 1'b1;
        idle(1);
        flush = 1'b0;
        idle(6);
        check("flush_empty_valid", 64'(bus.out_valid), 64'd0);
        check("flush_empty_level", 64'(fifo_level), 64'd0);

        // Overflow: 9 words into an 8-deep FIFO with no consumer
        for (int i = 1; i <= 36; i++) drive(32'(i));
        idle(6);
        check("ovf_level", 64'(fifo_level), 64'd8);
        check("ovf_sticky", 64'(overflow_sticky), 64'd1);
        for (int w = 0; w < 8; w++)
            expect_pop($sformatf("drain%0d", w),
                       {8'(4*w+4), 8'(4*w+3), 8'(4*w+2), 8'(4*w+1)}, 3'd4);
        idle(1);
        check("ovf_9th_absent", 64'(bus.out_valid), 64'd0);
        check("ovf_sat_kept", 64'(sat_count), 64'd2);
        clear_status = 1'b1;
        idle(1);
        clear_status = 1'b0;
        check("clr_sticky", 64'(overflow_sticky), 64'd0);
        check("clr_sat", 64'(sat_count), 64'd0);

        // Reset with 3 words queued and 2 lanes pending
        for (int i = 1; i <= 14; i++) drive(32'(i + 40));
        idle(6);
        check("pre_rst_level", 64'(fifo_level), 64'd3);
        rst_n = 1'b0;
        #1;
        check_reset_state("mid_rst");
        idle(1);
        rst_n = 1'b1;
        idle(1);
        for (int i = 1; i <= 4; i++) drive(32'(i));
        expect_pop("post_rst", 32'h04030201, 3'd4);
        idle(2);
        check("post_rst_empty", 64'(bus.out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
